// File: rtl/spi_cmd_sequencer_if.sv
// Bundle of the command, response and SPI-driver signals of spi_cmd_sequencer.
//
// Handshake rule for the cmd_* and rsp_* channels: a transfer happens on a
// rising clk edge where both valid and ready are 1. The producer holds its
// payload stable while valid is 1 and it has not yet seen ready.
interface spi_cmd_sequencer_if #(
  parameter int PACKAGE_SIZE = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_rw;
  logic [PACKAGE_SIZE-2:0] cmd_addr;
  logic [PACKAGE_SIZE-1:0] cmd_data;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [PACKAGE_SIZE-2:0] rsp_addr;
  logic [PACKAGE_SIZE-1:0] rsp_data;

  logic                    spi_rw_op;
  logic [PACKAGE_SIZE-2:0] spi_addr;
  logic [PACKAGE_SIZE-1:0] spi_data;
  logic                    spi_send;
  logic                    spi_busy;
  logic                    spi_data_ready;
  logic [PACKAGE_SIZE-1:0] spi_data_out;

  // Sequencer side.
  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_addr, rsp_data,
    input  rsp_ready,
    output spi_rw_op, spi_addr, spi_data, spi_send,
    input  spi_busy, spi_data_ready, spi_data_out
  );

  // Environment side: command source, response sink and SPI driver.
  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_addr, rsp_data,
    output rsp_ready,
    input  spi_rw_op, spi_addr, spi_data, spi_send,
    output spi_busy, spi_data_ready, spi_data_out
  );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// Queues register read/write commands and plays them one at a time into an
// SPI driver, returning read results on a response channel. Every wait on the
// driver is bounded by a timer; an expired wait drops the command and raises
// a sticky error flag.
module spi_cmd_sequencer #(
  parameter int PACKAGE_SIZE = 8,
  parameter int DEPTH        = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_cmd_sequencer_if.master    bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   timeout_err,
  input  logic                   err_clr,
  output logic                   idle,
  output logic [1:0]             o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = 2 * PACKAGE_SIZE;      // {rw, addr, data}
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [FW-1:0]           r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [AW:0]             r_level;

  logic [TW-1:0]           r_timer;
  logic                    r_spi_rw;
  logic [PACKAGE_SIZE-2:0] r_spi_addr;
  logic [PACKAGE_SIZE-1:0] r_spi_data;
  logic                    r_spi_send;
  logic                    r_rsp_valid;
  logic [PACKAGE_SIZE-2:0] r_rsp_addr;
  logic [PACKAGE_SIZE-1:0] r_rsp_data;
  logic                    r_timeout_err;

  logic                    w_push;
  logic                    w_launch;
  logic                    w_busy_seen;
  logic                    w_capture;
  logic                    w_timeout;
  logic                    w_timer_clr;
  logic                    w_timer_inc;
  logic                    w_timer_exp;
  logic [FW-1:0]           w_head;

  assign w_push      = bus.cmd_valid && bus.cmd_ready;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_timer_exp = (r_timer == TIMER_END);

  assign bus.cmd_ready = (r_level != LVL_FULL);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_addr  = r_rsp_addr;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.spi_rw_op = r_spi_rw;
  assign bus.spi_addr  = r_spi_addr;
  assign bus.spi_data  = r_spi_data;
  assign bus.spi_send  = r_spi_send;

  assign level       = r_level;
  assign timeout_err = r_timeout_err;
  assign idle        = (r_state == ST_IDLE) && (r_level == '0);
  assign o_dbg_state = r_state;

  // Command storage; the array itself needs no reset because the pointers guard it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.cmd_rw, bus.cmd_addr, bus.cmd_data};
  end

  // FIFO pointers and occupancy; a pop is a launch out of IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push)   r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_launch) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_launch})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and per-cycle actions; the timer only runs while waiting on the driver.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_busy_seen = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_timer_clr = 1'b0;
    w_timer_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_level != '0) begin
          w_launch    = 1'b1;
          w_timer_clr = 1'b1;
          w_state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (bus.spi_busy) begin
          w_busy_seen = 1'b1;
          w_timer_clr = 1'b1;
          w_state_nxt = ST_ACTIVE;
        end else if (w_timer_exp) begin
          w_timeout   = 1'b1;
          w_timer_clr = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!bus.spi_busy) begin
          if (r_spi_rw) begin
            w_timer_clr = 1'b1;
            w_state_nxt = ST_CAPTURE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_timer_exp) begin
          w_timeout   = 1'b1;
          w_timer_clr = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Data present but response slot still occupied: stall without counting.
        if (bus.spi_data_ready) begin
          if (!r_rsp_valid || bus.rsp_ready) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_timer_exp) begin
          w_timeout   = 1'b1;
          w_timer_clr = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Wait timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_timer <= '0;
    else if (w_timer_clr) r_timer <= '0;
    else if (w_timer_inc) r_timer <= r_timer + TW'(1);
  end

  // SPI driver outputs: loaded at launch, held until the next launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spi_rw   <= 1'b0;
      r_spi_addr <= '0;
      r_spi_data <= '0;
      r_spi_send <= 1'b0;
    end else if (w_launch) begin
      r_spi_rw   <= w_head[FW-1];
      r_spi_addr <= w_head[FW-2 -: (PACKAGE_SIZE-1)];
      r_spi_data <= w_head[PACKAGE_SIZE-1:0];
      r_spi_send <= 1'b1;
    end else if (w_busy_seen || w_timeout) begin
      r_spi_send <= 1'b0;
    end
  end

  // Response register; a capture in the same cycle as a consume keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_addr  <= r_spi_addr;
      r_rsp_data  <= bus.spi_data_out;
    end else if (r_rsp_valid && bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_timeout_err <= 1'b0;
    else if (w_timeout) r_timeout_err <= 1'b1;
    else if (err_clr)   r_timeout_err <= 1'b0;
  end

endmodule
